// File: rtl/bnn_result_tx_if.sv
// Result/host handshake bundle for bnn_result_tx.
// slave: the transmitter side; master: the BNN core + host side.
interface bnn_result_tx_if #(
   parameter int SCORE_W = 6
);
   logic                 res_valid;
   logic [7-SCORE_W:0]   res_class;
   logic [SCORE_W-1:0]   res_score;
   logic                 host_ack;
   logic [7:0]           tx_data;
   logic                 tx_valid;

   modport slave (
      input  res_valid, res_class, res_score, host_ack,
      output tx_data, tx_valid
   );

   modport master (
      output res_valid, res_class, res_score, host_ack,
      input  tx_data, tx_valid
   );
endinterface

// File: rtl/bnn_result_tx.sv
// BNN result queue and 4-phase byte transmitter toward the host pins.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | no byte on the pins; pops the head when allowed
// PRESENT  | tx_valid high, tx_data held until synchronized ack rises
// WAIT_LOW | tx_valid low, waiting for synchronized ack to fall
module bnn_result_tx #(
   parameter int DEPTH   = 4,
   parameter int SCORE_W = 6,
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             clr_ovf,
   bnn_result_tx_if.slave   bus,
   output logic             fifo_full,
   output logic [LVL_W-1:0] fifo_level,
   output logic             overflow
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESENT  = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             ack_meta, ack_s;
   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [LVL_W-1:0] level_q;
   logic [7:0]       tx_data_q;
   logic             ovf_q;

   logic full, pop, push_req, push, drop;

   // Full uses pre-edge occupancy; a same-edge pop frees the slot for the push.
   assign full     = (level_q == LVL_W'(DEPTH));
   assign pop      = (state_q == IDLE) && ena && (level_q != '0) && !ack_s;
   assign push_req = bus.res_valid && ena;
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   // Two-flop synchronizer for the asynchronous host acknowledge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_meta <= 1'b0;
         ack_s    <= 1'b0;
      end else begin
         ack_meta <= bus.host_ack;
         ack_s    <= ack_meta;
      end
   end

   // FIFO storage; contents need no reset since level gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {bus.res_class, bus.res_score};
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Sticky overflow; a drop on the same edge as clr_ovf keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ovf_q <= 1'b0;
      else if (drop)    ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
   end

   // Output byte register, loaded only when the head is popped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   tx_data_q <= 8'h00;
      else if (pop) tx_data_q <= mem[rd_ptr];
   end

   // Handshake state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; a started handshake finishes regardless of ena.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (pop)    state_d = PRESENT;
         PRESENT:  if (ack_s)  state_d = WAIT_LOW;
         WAIT_LOW: if (!ack_s) state_d = IDLE;
         default:              state_d = IDLE;
      endcase
   end

   assign bus.tx_valid = (state_q == PRESENT);
   assign bus.tx_data  = tx_data_q;
   assign fifo_full    = full;
   assign fifo_level   = level_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_bnn_result_tx.sv
// Bench for bnn_result_tx: directed scenarios plus a randomized fill phase
// against a queue-based model of the result FIFO and overflow flag.
module tb_bnn_result_tx;
   localparam int DEPTH = 4;
   localparam int SW    = 6;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ena;
   logic          clr_ovf;
   logic          fifo_full;
   logic [LW-1:0] fifo_level;
   logic          overflow;

   bnn_result_tx_if #(.SCORE_W(SW)) bus ();

   bnn_result_tx #(.DEPTH(DEPTH), .SCORE_W(SW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .clr_ovf    (clr_ovf),
      .bus        (bus.slave),
      .fifo_full  (fifo_full),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] q[$];
   bit         ovf_m = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One clock with the given inputs; model assumes no pop can happen this edge.
   task automatic drive(input bit v, input logic [7:0] d, input bit c);
      bit full_pre;
      bus.res_valid = v;
      bus.res_class = d[7:SW];
      bus.res_score = d[SW-1:0];
      clr_ovf       = c;
      full_pre      = (q.size() == DEPTH);
      step();
      if (v && ena && !full_pre) q.push_back(d);
      if (v && ena && full_pre) ovf_m = 1'b1;
      else if (c)               ovf_m = 1'b0;
      bus.res_valid = 1'b0;
      clr_ovf       = 1'b0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_level"}, 32'(fifo_level), q.size());
      chk({tag, "_full"}, 32'(fifo_full), 32'(q.size() == DEPTH));
      chk({tag, "_ovf"}, 32'(overflow), 32'(ovf_m));
   endtask

   // Hold ack high long enough that the synchronized ack blocks all pops.
   task automatic block_pops();
      bus.host_ack = 1'b1;
      repeat (3) step();
   endtask

   task automatic ack_phase();
      int n;
      bus.host_ack = 1'b1;
      n = 0;
      while (bus.tx_valid === 1'b1 && n < 8) begin
         step();
         n++;
      end
      chk("ack_to_valid_low_edges", n, 3);
      bus.host_ack = 1'b0;
   endtask

   task automatic host_xfer();
      logic [7:0] exp;
      int n;
      exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
      bus.host_ack = 1'b0;
      n = 0;
      while (bus.tx_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("xfer_valid", 32'(bus.tx_valid), 1);
      chk("xfer_data", 32'(bus.tx_data), 32'(exp));
      ack_phase();
   endtask

   initial begin
      logic [7:0] d;
      int         n;
      bit         v, c;

      rst_n         = 1'b0;
      ena           = 1'b0;
      clr_ovf       = 1'b0;
      bus.res_valid = 1'b0;
      bus.res_class = '0;
      bus.res_score = '0;
      bus.host_ack  = 1'b0;
      #12;
      chk("rst_tx_valid", 32'(bus.tx_valid), 0);
      chk("rst_tx_data", 32'(bus.tx_data), 0);
      check_state("rst");
      rst_n = 1'b1;
      ena   = 1'b1;

      // Single result: class 2, score 37 -> 0xA5, first edge after reset.
      drive(1'b1, 8'hA5, 1'b0);
      chk("single_e0_valid", 32'(bus.tx_valid), 0);
      check_state("single_e0");
      step();
      void'(q.pop_front());
      chk("single_e1_valid", 32'(bus.tx_valid), 1);
      chk("single_e1_data", 32'(bus.tx_data), 32'h A5);
      check_state("single_e1");
      ack_phase();
      repeat (3) step();
      chk("single_done_valid", 32'(bus.tx_valid), 0);
      chk("single_data_kept", 32'(bus.tx_data), 32'hA5);
      check_state("single_done");

      // Burst with ack stalled high, then overflow, then in-order drain.
      block_pops();
      drive(1'b1, 8'h11, 1'b0);
      drive(1'b1, 8'h22, 1'b0);
      drive(1'b1, 8'h33, 1'b0);
      drive(1'b1, 8'h44, 1'b0);
      chk("burst_no_valid", 32'(bus.tx_valid), 0);
      check_state("burst_full");
      drive(1'b1, 8'h99, 1'b0);
      check_state("burst_ovf");
      repeat (4) host_xfer();
      check_state("burst_drained");
      drive(1'b0, 8'h00, 1'b1);
      check_state("clr_ovf");

      // Full FIFO: pop and push on the same edge.
      block_pops();
      drive(1'b1, 8'h11, 1'b0);
      drive(1'b1, 8'h22, 1'b0);
      drive(1'b1, 8'h33, 1'b0);
      drive(1'b1, 8'h44, 1'b0);
      bus.host_ack = 1'b0;
      step();
      step();
      bus.res_valid = 1'b1;
      bus.res_class = 2'b01;
      bus.res_score = 6'h15;
      step();
      bus.res_valid = 1'b0;
      void'(q.pop_front());
      q.push_back(8'h55);
      check_state("fullpop");
      chk("fullpop_valid", 32'(bus.tx_valid), 1);
      chk("fullpop_data", 32'(bus.tx_data), 32'h11);
      ack_phase();
      repeat (4) host_xfer();
      check_state("fullpop_drained");

      // Dropped push and clr_ovf on the same edge: set wins.
      block_pops();
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
      drive(1'b1, 8'h77, 1'b1);
      check_state("set_wins");
      drive(1'b0, 8'h00, 1'b1);
      check_state("set_wins_clr");
      repeat (4) host_xfer();

      // ena gating: pushes ignored, then ena dropped mid-handshake.
      ena = 1'b0;
      repeat (3) drive(1'b1, 8'hE7, 1'b0);
      check_state("ena_off");
      ena = 1'b1;
      block_pops();
      drive(1'b1, 8'h3C, 1'b0);
      drive(1'b1, 8'hC3, 1'b0);
      bus.host_ack = 1'b0;
      n = 0;
      while (bus.tx_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("ena_present_valid", 32'(bus.tx_valid), 1);
      chk("ena_present_data", 32'(bus.tx_data), 32'h3C);
      void'(q.pop_front());
      ena = 1'b0;
      ack_phase();
      repeat (8) step();
      chk("ena_hold_valid", 32'(bus.tx_valid), 0);
      check_state("ena_hold");
      ena = 1'b1;
      host_xfer();

      // Randomized fill phase with pops blocked, then drain in order.
      ena = 1'b0;
      block_pops();
      for (int i = 0; i < 200; i++) begin
         ena = (($urandom % 4) != 0);
         v   = 1'($urandom % 2);
         c   = (($urandom % 8) == 0);
         d   = 8'($urandom);
         drive(v, d, c);
         check_state("rand");
      end
      ena = 1'b1;
      n = 0;
      while (q.size() > 0 && n < 10) begin
         host_xfer();
         n++;
      end
      check_state("rand_drained");

      // Asynchronous reset mid-handshake with level 3.
      block_pops();
      drive(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'hB0 + i), 1'b0);
      bus.host_ack = 1'b0;
      n = 0;
      while (bus.tx_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      void'(q.pop_front());
      chk("rst_mid_valid", 32'(bus.tx_valid), 1);
      check_state("rst_mid_pre");
      rst_n = 1'b0;
      #2;
      q.delete();
      ovf_m = 1'b0;
      chk("rst_mid_tx_valid", 32'(bus.tx_valid), 0);
      chk("rst_mid_tx_data", 32'(bus.tx_data), 0);
      check_state("rst_mid");
      #2;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.tx_valid !== 1'b0) n++;
      end
      chk("rst_release_no_valid", n, 0);
      check_state("rst_release");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bnn_result_tx.md
BNN_RESULT_TX -- requirements
Module: bnn_result_tx

Interface
REQ-001 Parameter DEPTH, default 4: result FIFO depth in entries; power of two, 2..16.
REQ-002 Parameter SCORE_W, default 6: width of the BNN score field; res_class width = 8-SCORE_W.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  design enable from the tile harness.
REQ-006 res_valid  input  1  one-cycle strobe from BNN core: result ready.
REQ-007 res_class  input  8-SCORE_W  predicted class index.
REQ-008 res_score  input  SCORE_W  popcount margin of winning class.
REQ-009 host_ack  input  1  host acknowledge (uio_in bit), asynchronous to clk.
REQ-010 clr_ovf  input  1  one-cycle strobe: clear overflow flag.
REQ-011 tx_data  output  8  result byte to uo_out, {res_class, res_score}.
REQ-012 tx_valid  output  1  byte-valid strobe to uio_out bit (4-phase request).
REQ-013 fifo_full  output  1  FIFO holds DEPTH entries.
REQ-014 fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 overflow  output  1  sticky: a result was dropped.

Function
REQ-016 Push: res_valid=1 and ena=1 at a rising edge writes {res_class,res_score} to the FIFO tail, unless full.
REQ-017 Full is evaluated on pre-edge occupancy; a push while full is discarded and sets overflow, except when a pop occurs on the same edge, in which case the push is accepted and level stays DEPTH.
REQ-018 res_valid with ena=0 is ignored and does not set overflow.
REQ-019 host_ack passes through a 2-flop synchronizer (ack_s); the FSM uses only ack_s.
REQ-020 FSM states: IDLE, PRESENT, WAIT_LOW; 4-phase handshake.
REQ-021 IDLE: if ena=1, FIFO non-empty and ack_s=0, pop head into tx_data, tx_valid<=1, go PRESENT; else hold.
REQ-022 PRESENT: tx_valid=1, tx_data stable; on ack_s=1, tx_valid<=0, go WAIT_LOW.
REQ-023 WAIT_LOW: tx_valid=0; on ack_s=0 go IDLE; tx_data keeps the last byte.
REQ-024 An in-progress handshake (PRESENT/WAIT_LOW) completes regardless of ena; ena=0 only blocks new pops and pushes.
REQ-025 Latency: push edge E0 on an empty FIFO in IDLE -> tx_valid high after edge E1 (one clock later).
REQ-026 host_ack rising -> tx_valid falls on the 3rd rising edge after host_ack is first sampled high.
REQ-027 Pointers wrap modulo DEPTH; level = pushes - pops, never exceeds DEPTH, never underflows.
REQ-028 clr_ovf clears overflow; if clr_ovf and a dropped push coincide, overflow ends 1 (set wins).
REQ-029 fifo_full = (fifo_level == DEPTH), registered-consistent with level.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, tx_valid 0, tx_data 8'h00, FIFO empty (level 0, pointers 0), fifo_full 0, overflow 0, synchronizer flops 0.
REQ-031 Reset mid-handshake drops the in-flight byte and all queued entries; no tx_valid pulse on release until a new push.
REQ-032 First push is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-033 Single result: ena=1, push class=2 score=6'd37 -> tx_data=8'hA5, tx_valid=1 one clock later; ack high -> tx_valid 0 within 3 edges; ack low -> IDLE, level 0.
REQ-034 Burst: 4 pushes 8'h11,22,33,44 with host ack stalled high -> no tx_valid, fifo_full=1; 5th push -> overflow=1, level 4; release ack, handshake 4 times -> bytes 11,22,33,44 in order.
REQ-035 Full + simultaneous pop: FIFO full, IDLE pops while res_valid pushes 8'h55 -> level stays 4, overflow stays 0, 8'h55 delivered last.
REQ-036 ena gating: ena=0 with res_valid pulses -> level 0, overflow 0; ena dropped during PRESENT -> handshake completes, next entry not popped until ena=1.
REQ-037 Reset mid-operation: level 3, state PRESENT, assert rst_n=0 -> tx_valid 0, tx_data 00, level 0 immediately; after release no tx_valid without new push.
REQ-038 clr_ovf: overflow=1, pulse clr_ovf -> overflow 0 next edge; clr_ovf coinciding with dropped push -> overflow 1.
